// File: rtl/write_back_queue.sv
// Write-back queue: buffers register write-back requests and drains one per clock
// into the register file write port. Optional decode bypass lookup under WBQ_BYPASS_EN.
module write_back_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [ADDR_W-1:0]            inReg,
  input  logic [DATA_W-1:0]            inData,
  input  logic                         holdWrite,
  output logic [ADDR_W-1:0]            writeReg,
  output logic                         writeEn,
  output logic [DATA_W-1:0]            writeData,
`ifdef WBQ_BYPASS_EN
  input  logic [ADDR_W-1:0]            lookupReg1,
  input  logic [ADDR_W-1:0]            lookupReg2,
  output logic                         hit1,
  output logic                         hit2,
  output logic [DATA_W-1:0]            hitData1,
  output logic [DATA_W-1:0]            hitData2,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] qReg  [DEPTH];
  logic [DATA_W-1:0] qData [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              store;
  logic              pop;

  assign inReady = count < CNT_W'(DEPTH);
  assign push    = inValid && inReady;
  // Writes to register 0 complete the handshake but are dropped.
  assign store   = push && (inReg != '0);
  assign pop     = (count != '0) && !holdWrite;

  // Entry storage needs no reset: validity is tracked by head/count.
  always_ff @(posedge CLK) begin
    if (store) begin
      qReg[tail]  <= inReg;
      qData[tail] <= inData;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      writeEn   <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      writeEn <= pop;
      if (store) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head      <= head + PTR_W'(1);
        writeReg  <= qReg[head];
        writeData <= qData[head];
      end
      if (store && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !store) begin
        count <= count - CNT_W'(1);
      end
    end
  end

`ifdef WBQ_BYPASS_EN
  // Youngest match wins: scan output register first, then head to newest entry.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (r != '0) begin
      if (writeEn && (writeReg == r)) begin
        res = {1'b1, writeData};
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx = head + PTR_W'(i);
        if ((CNT_W'(i) < count) && (qReg[idx] == r)) begin
          res = {1'b1, qData[idx]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    {hit1, hitData1} = lookup(lookupReg1);
    {hit2, hitData2} = lookup(lookupReg2);
  end
`endif

endmodule

// File: tb/tb_write_back_queue.sv
// Self-checking bench for write_back_queue: table-driven vectors plus hand sequences
// for reset, streaming wrap and (with WBQ_BYPASS_EN) the bypass lookup.
module tb_write_back_queue;

  logic        CLK;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [4:0]  inReg;
  logic [31:0] inData;
  logic        holdWrite;
  logic [4:0]  writeReg;
  logic        writeEn;
  logic [31:0] writeData;
  logic [2:0]  count;
`ifdef WBQ_BYPASS_EN
  logic [4:0]  lookupReg1;
  logic [4:0]  lookupReg2;
  logic        hit1;
  logic        hit2;
  logic [31:0] hitData1;
  logic [31:0] hitData2;
`endif

  int total;
  int bad;

  write_back_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .inValid   (inValid),
    .inReady   (inReady),
    .inReg     (inReg),
    .inData    (inData),
    .holdWrite (holdWrite),
    .writeReg  (writeReg),
    .writeEn   (writeEn),
    .writeData (writeData),
`ifdef WBQ_BYPASS_EN
    .lookupReg1(lookupReg1),
    .lookupReg2(lookupReg2),
    .hit1      (hit1),
    .hit2      (hit2),
    .hitData1  (hitData1),
    .hitData2  (hitData2),
`endif
    .count     (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        inValid;
    logic [4:0]  inReg;
    logic [31:0] inData;
    logic        holdWrite;
    logic        expEn;
    logic [4:0]  expReg;
    logic [31:0] expData;
    logic [2:0]  expCount;
    logic        expReady;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic en, input logic [4:0] r,
                          input logic [31:0] d, input logic [2:0] c, input logic rdy);
    check({tag, " writeEn"},   32'(writeEn),   32'(en));
    check({tag, " writeReg"},  32'(writeReg),  32'(r));
    check({tag, " writeData"}, writeData,      d);
    check({tag, " count"},     32'(count),     32'(c));
    check({tag, " inReady"},   32'(inReady),   32'(rdy));
  endtask

  // Drive inputs for one cycle, then sample just after the rising edge.
  task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d, input logic h);
    inValid   = v;
    inReg     = r;
    inData    = d;
    holdWrite = h;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // inValid inReg inData holdWrite | expEn expReg expData expCount expReady
    vecs[0]  = '{1'b1, 5'd1,  32'd15,    1'b0, 1'b0, 5'd0,  32'd0,     3'd1, 1'b1};
    vecs[1]  = '{1'b0, 5'd0,  32'd0,     1'b0, 1'b1, 5'd1,  32'd15,    3'd0, 1'b1};
    vecs[2]  = '{1'b0, 5'd0,  32'd0,     1'b0, 1'b0, 5'd1,  32'd15,    3'd0, 1'b1};
    vecs[3]  = '{1'b1, 5'd1,  32'd15,    1'b1, 1'b0, 5'd1,  32'd15,    3'd1, 1'b1};
    vecs[4]  = '{1'b1, 5'd2,  32'd30,    1'b1, 1'b0, 5'd1,  32'd15,    3'd2, 1'b1};
    vecs[5]  = '{1'b1, 5'd31, 32'h4AD,   1'b1, 1'b0, 5'd1,  32'd15,    3'd3, 1'b1};
    vecs[6]  = '{1'b1, 5'd3,  32'd7,     1'b1, 1'b0, 5'd1,  32'd15,    3'd4, 1'b0};
    vecs[7]  = '{1'b1, 5'd9,  32'h99,    1'b1, 1'b0, 5'd1,  32'd15,    3'd4, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'd0,     1'b0, 1'b1, 5'd1,  32'd15,    3'd3, 1'b1};
    vecs[9]  = '{1'b0, 5'd0,  32'd0,     1'b0, 1'b1, 5'd2,  32'd30,    3'd2, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'd0,     1'b0, 1'b1, 5'd31, 32'h4AD,   3'd1, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'd0,     1'b0, 1'b1, 5'd3,  32'd7,     3'd0, 1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'd0,     1'b0, 1'b0, 5'd3,  32'd7,     3'd0, 1'b1};
    vecs[13] = '{1'b1, 5'd0,  32'd99,    1'b0, 1'b0, 5'd3,  32'd7,     3'd0, 1'b1};
    vecs[14] = '{1'b1, 5'd5,  32'd1,     1'b0, 1'b0, 5'd3,  32'd7,     3'd1, 1'b1};
    vecs[15] = '{1'b0, 5'd0,  32'd0,     1'b0, 1'b1, 5'd5,  32'd1,     3'd0, 1'b1};
    vecs[16] = '{1'b0, 5'd0,  32'd0,     1'b0, 1'b0, 5'd5,  32'd1,     3'd0, 1'b1};

    reset     = 1'b0;
    inValid   = 1'b0;
    inReg     = '0;
    inData    = '0;
    holdWrite = 1'b0;
`ifdef WBQ_BYPASS_EN
    lookupReg1 = '0;
    lookupReg2 = '0;
`endif
    #1;
    checkOut("reset0", 1'b0, 5'd0, 32'd0, 3'd0, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].inValid, vecs[i].inReg, vecs[i].inData, vecs[i].holdWrite);
      checkOut($sformatf("vec%0d", i), vecs[i].expEn, vecs[i].expReg,
               vecs[i].expData, vecs[i].expCount, vecs[i].expReady);
    end

    // Back-to-back stream across the pointer wrap.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 5'(10 + k), 32'(100 + k), 1'b0);
      check($sformatf("stream%0d count", k), 32'(count), 32'd1);
      if (k > 0) begin
        check($sformatf("stream%0d writeEn", k), 32'(writeEn), 32'd1);
        check($sformatf("stream%0d writeReg", k), 32'(writeReg), 32'(10 + k - 1));
        check($sformatf("stream%0d writeData", k), writeData, 32'(100 + k - 1));
      end
    end
    step(1'b0, 5'd0, 32'd0, 1'b0);
    checkOut("streamTail", 1'b1, 5'd19, 32'd109, 3'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    check("streamIdle writeEn", 32'(writeEn), 32'd0);

    // Mid-stream reset with three entries queued and a write in flight.
    step(1'b1, 5'd4,  32'd40,  1'b1);
    step(1'b1, 5'd6,  32'd60,  1'b1);
    step(1'b1, 5'd8,  32'd80,  1'b1);
    step(1'b1, 5'd12, 32'd120, 1'b1);
    step(1'b0, 5'd0,  32'd0,   1'b0);
    checkOut("preReset", 1'b1, 5'd4, 32'd40, 3'd3, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOut("asyncReset", 1'b0, 5'd0, 32'd0, 3'd0, 1'b1);
    @(negedge CLK);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0);
      check($sformatf("postReset%0d writeEn", k), 32'(writeEn), 32'd0);
      check($sformatf("postReset%0d count", k), 32'(count), 32'd0);
    end

`ifdef WBQ_BYPASS_EN
    // Youngest match wins, output register is lowest priority.
    lookupReg1 = 5'd7;
    lookupReg2 = 5'd0;
    step(1'b1, 5'd7, 32'hA, 1'b1);
    step(1'b1, 5'd7, 32'hB, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1);
    check("byp hit1", 32'(hit1), 32'd1);
    check("byp hitData1", hitData1, 32'hB);
    check("byp hit2", 32'(hit2), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    check("bypPop1 hitData1", hitData1, 32'hB);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    check("bypPop2 hit1", 32'(hit1), 32'd1);
    check("bypPop2 hitData1", hitData1, 32'hB);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    check("bypIdle hit1", 32'(hit1), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_back_queue.md
# write_back_queue

Buffers register write-back requests from the execute stage and drains them, one per clock, into the single write port of the 32x32-bit register file (`writeReg`/`writeEn`/`writeData`). It sits directly upstream of the register file and decouples bursty producers (ALU, load unit) from the file's one-write-per-cycle limit. An optional bypass path lets decode read operands still pending in the queue.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `DATA_W`, 32: write data width.
- `ADDR_W`, 5: register address width.

- `CLK`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset. Clears the queue and all outputs immediately on assertion.
- `inValid`  in  1  producer offers a write-back request.
- `inReady`  out  1  queue can accept a request; combinational, equals `count < DEPTH`.
- `inReg`  in  ADDR_W  destination register.
- `inData`  in  DATA_W  data to write.
- `holdWrite`  in  1  when 1, no entry is popped this cycle.
- `writeReg`  out  ADDR_W  registered; to register file.
- `writeEn`  out  1  registered; to register file.
- `writeData`  out  DATA_W  registered; to register file.
- `count`  out  clog2(DEPTH+1)  entries currently queued. Excludes the output register.
- `lookupReg1`, `lookupReg2`  in  ADDR_W  bypass query addresses. Present only with `WBQ_BYPASS_EN`.
- `hit1`, `hit2`  out  1  a pending write matches. Present only with `WBQ_BYPASS_EN`.
- `hitData1`, `hitData2`  out  DATA_W  data of the youngest match. Present only with `WBQ_BYPASS_EN`.

## Operation
- Circular buffer with head/tail pointers. Pointer wrap is at `DEPTH`, natural binary wrap.
- Push occurs when `inValid && inReady` at a rising edge. The entry `{inReg, inData}` is written at the tail and the tail advances.
- A push with `inReg == 0` is accepted (a handshake completes) but nothing is stored, and `count` is unchanged. Register 0 is never written.
- Pop occurs at a rising edge when `count != 0 && !holdWrite`:
  - the head entry is loaded into `writeReg`/`writeData`;
  - `writeEn` is set to 1;
  - the head advances.
- On a cycle with no pop, `writeEn` returns to 0. `writeReg` and `writeData` hold their last values.
- When push and pop happen at the same edge, `count` is unchanged.
- `inReady` depends only on `count`. When the queue is full, it stays 0 even in a cycle that pops.
- Request order is preserved exactly, including repeated writes to the same register.
- Reset values:
  - `writeEn` 0, `writeReg` 0, `writeData` 0;
  - `count` 0, so `inReady` is 1;
  - pointers 0.
- Reset asserted mid-operation discards all pending entries and any in-flight `writeEn`.

## Timing
- Empty queue:
  - request accepted at edge N;
  - `writeEn` is 1 in the cycle after edge N+1;
  - the register file captures the write at edge N+2.
- Throughput is one write per cycle while `holdWrite` is 0.
- `holdWrite` is sampled at the edge. Asserting it in cycle k suppresses the pop at the end of cycle k.

## Configuration
- `WBQ_BYPASS_EN` defined:
  - lookup ports exist;
  - `hitN` is 1 when `lookupRegN != 0` and it matches any valid queue entry, or the output register while `writeEn` is 1;
  - `hitDataN` is the youngest match, with priority newest queue entry > … > head > output register;
  - the outputs are combinational;
  - the lookup does not see an entry pushed in the same cycle.
- Undefined:
  - lookup ports and logic are absent;
  - decode must stall until `count == 0 && !writeEn`.

## Test plan
- Reset:
  - assert `reset` = 0 mid-stream with 3 entries queued;
  - required: `count` = 0, `writeEn` = 0, `inReady` = 1 immediately;
  - no further writes after release.
- Basic latency: push (1, 15) at edge N into an empty queue -> `writeEn` = 1, `writeReg` = 1, `writeData` = 15 for exactly one cycle after edge N+1.
- Full queue and ordering:
  - with `holdWrite` = 1, push (1,15), (2,30), (31,0x4AD), (3,7);
  - required: `count` = 4, `inReady` = 0, and a fifth offer is not accepted;
  - release `holdWrite` -> the four writes appear on consecutive cycles in that order.
- Register 0:
  - push (0, 99), then (5, 1);
  - required: both handshakes complete, `count` peaks at 1, and only register 5 is written.
- Simultaneous push and pop with pointer wrap:
  - stream 10 back-to-back pushes with DEPTH = 4 and `holdWrite` = 0;
  - required: `count` stays ≤1 and all 10 writes emerge in order.
- Bypass (`WBQ_BYPASS_EN`):
  - queue (7, 0xA), then (7, 0xB), and hold;
  - `lookupReg1` = 7 -> `hit1` = 1, `hitData1` = 0xB;
  - `lookupReg2` = 0 -> `hit2` = 0.
